// File: rtl/run_status_monitor.sv
// rtl/run_status_monitor.sv - run supervisor: write-window watch, cycle budget, sticky run status
module run_status_monitor #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_LO = ADDR_WIDTH'(32'h0020_0000),
  parameter logic [ADDR_WIDTH-1:0] WIN_HI = ADDR_WIDTH'(32'h0024_0000),
  parameter int unsigned CYCLE_WIDTH = 32,
  parameter bit          VIOL_FATAL  = 1'b0,
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [CYCLE_WIDTH-1:0]          max_cycles_i,
  input  logic [NUM_PORTS-1:0]            wr_req_i,
  input  logic [NUM_PORTS-1:0]            wr_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                            tests_passed_i,
  input  logic                            tests_failed_i,
  input  logic                            exit_valid_i,
  input  logic [31:0]                     exit_value_i,
  output logic [2:0]                      status_o,
  output logic                            done_o,
  output logic [CYCLE_WIDTH-1:0]          cycle_cnt_o,
  output logic [31:0]                     exit_value_o,
  output logic [15:0]                     viol_cnt_o,
  output logic                            viol_valid_o,
  output logic [ADDR_WIDTH-1:0]           viol_addr_o,
  output logic [PW-1:0]                   viol_port_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_PASS     = 3'd2,
    S_FAIL     = 3'd3,
    S_EXIT_OK  = 3'd4,
    S_EXIT_ERR = 3'd5,
    S_TIMEOUT  = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [CYCLE_WIDTH-1:0]  cycle_cnt_q;
  logic [31:0]             exit_value_q;
  logic [15:0]             viol_cnt_q, viol_cnt_next;
  logic                    viol_valid_q;
  logic [ADDR_WIDTH-1:0]   viol_addr_q, first_addr;
  logic [PW-1:0]           viol_port_q, first_port;
  logic [NUM_PORTS-1:0]    viol_vec;
  logic [16:0]             viol_sum;
  logic                    any_viol;
  logic                    timeout_hit;

  // Violation detect, popcount and lowest-index capture across all ports
  always_comb begin
    viol_vec   = '0;
    viol_sum   = {1'b0, viol_cnt_q};
    first_port = '0;
    first_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      viol_vec[p] = wr_req_i[p] & wr_we_i[p] &
                    ((wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] < WIN_LO) |
                     (wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] > WIN_HI));
      viol_sum    = viol_sum + 17'(viol_vec[p]);
    end
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (viol_vec[p]) begin
        first_port = PW'(p);
        first_addr = wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    any_viol      = |viol_vec;
    viol_cnt_next = viol_sum[16] ? 16'hFFFF : viol_sum[15:0];
  end

  // Equality compare on purpose: lowering the budget mid-run never fires
  assign timeout_hit = (max_cycles_i != '0) &&
                       (cycle_cnt_q == max_cycles_i - CYCLE_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (tests_failed_i || (VIOL_FATAL && any_viol)) state_d = S_FAIL;
      else if (tests_passed_i)                        state_d = S_PASS;
      else if (exit_valid_i)
        state_d = (exit_value_i == 32'd0) ? S_EXIT_OK : S_EXIT_ERR;
      else if (timeout_hit)                           state_d = S_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cycle_cnt_q  <= '0;
      exit_value_q <= '0;
      viol_cnt_q   <= '0;
      viol_valid_q <= 1'b0;
      viol_addr_q  <= '0;
      viol_port_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        cycle_cnt_q  <= '0;
        exit_value_q <= '0;
        viol_cnt_q   <= '0;
        viol_valid_q <= 1'b0;
        viol_addr_q  <= '0;
        viol_port_q  <= '0;
      end else if (state_q == S_RUN) begin
        // The ending edge leaves the counter showing the cycle the event arrived in
        if (state_d == S_RUN && cycle_cnt_q != '1)
          cycle_cnt_q <= cycle_cnt_q + CYCLE_WIDTH'(1);
        viol_cnt_q <= viol_cnt_next;
        if (any_viol && !viol_valid_q) begin
          viol_valid_q <= 1'b1;
          viol_addr_q  <= first_addr;
          viol_port_q  <= first_port;
        end
        if (state_d == S_EXIT_OK || state_d == S_EXIT_ERR)
          exit_value_q <= exit_value_i;
      end
    end
  end

  assign status_o     = state_q;
  assign done_o       = (state_q != S_IDLE) && (state_q != S_RUN);
  assign cycle_cnt_o  = cycle_cnt_q;
  assign exit_value_o = exit_value_q;
  assign viol_cnt_o   = viol_cnt_q;
  assign viol_valid_o = viol_valid_q;
  assign viol_addr_o  = viol_addr_q;
  assign viol_port_o  = viol_port_q;

endmodule

// File: tb/tb_run_status_monitor.sv
// tb/tb_run_status_monitor.sv - directed bench for run_status_monitor
module tb_run_status_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] max_cycles_i = '0;
  logic [1:0]  wr_req_i = '0;
  logic [1:0]  wr_we_i = '0;
  logic [63:0] wr_addr_i = '0;
  logic        tests_passed_i = 1'b0;
  logic        tests_failed_i = 1'b0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;

  logic [2:0]  status_o, f_status_o;
  logic        done_o, f_done_o;
  logic [31:0] cycle_cnt_o, f_cycle_cnt_o;
  logic [31:0] exit_value_o, f_exit_value_o;
  logic [15:0] viol_cnt_o, f_viol_cnt_o;
  logic        viol_valid_o, f_viol_valid_o;
  logic [31:0] viol_addr_o, f_viol_addr_o;
  logic [0:0]  viol_port_o, f_viol_port_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  run_status_monitor #(.VIOL_FATAL(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .max_cycles_i(max_cycles_i),
    .wr_req_i(wr_req_i), .wr_we_i(wr_we_i), .wr_addr_i(wr_addr_i),
    .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
    .status_o(status_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o),
    .exit_value_o(exit_value_o), .viol_cnt_o(viol_cnt_o), .viol_valid_o(viol_valid_o),
    .viol_addr_o(viol_addr_o), .viol_port_o(viol_port_o)
  );

  run_status_monitor #(.VIOL_FATAL(1'b1)) dut_f (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .max_cycles_i(max_cycles_i),
    .wr_req_i(wr_req_i), .wr_we_i(wr_we_i), .wr_addr_i(wr_addr_i),
    .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
    .status_o(f_status_o), .done_o(f_done_o), .cycle_cnt_o(f_cycle_cnt_o),
    .exit_value_o(f_exit_value_o), .viol_cnt_o(f_viol_cnt_o), .viol_valid_o(f_viol_valid_o),
    .viol_addr_o(f_viol_addr_o), .viol_port_o(f_viol_port_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic write2(input logic [1:0] req, input logic [1:0] we,
                        input logic [31:0] a1, input logic [31:0] a0);
    wr_req_i  = req;
    wr_we_i   = we;
    wr_addr_i = {a1, a0};
    tick(1);
    wr_req_i  = '0;
    wr_we_i   = '0;
    wr_addr_i = '0;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_status", status_o, 3'd0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_cycle", cycle_cnt_o, 32'd0);
    chk("rst_viol_cnt", viol_cnt_o, 16'd0);
    rst_ni = 1'b1;
    tick(1);

    // 1: pass at RUN cycle 10
    pulse_start();
    chk("t1_run", status_o, 3'd1);
    chk("t1_cnt0", cycle_cnt_o, 32'd0);
    chk("t1_done0", done_o, 1'b0);
    tick(10);
    tests_passed_i = 1'b1;
    tick(1);
    tests_passed_i = 1'b0;
    chk("t1_pass", status_o, 3'd2);
    chk("t1_done", done_o, 1'b1);
    chk("t1_cnt", cycle_cnt_o, 32'd10);
    tick(5);
    chk("t1_sticky", status_o, 3'd2);
    chk("t1_frozen", cycle_cnt_o, 32'd10);

    // 2: budget of 100 cycles, then unlimited
    max_cycles_i = 32'd100;
    pulse_start();
    tick(99);
    chk("t2_pre_run", status_o, 3'd1);
    chk("t2_pre_cnt", cycle_cnt_o, 32'd99);
    tick(1);
    chk("t2_timeout", status_o, 3'd6);
    chk("t2_done", done_o, 1'b1);
    chk("t2_cnt", cycle_cnt_o, 32'd99);
    tick(10);
    chk("t2_frozen", cycle_cnt_o, 32'd99);
    max_cycles_i = 32'd0;
    pulse_start();
    tick(10001);
    chk("t2_nolimit", status_o, 3'd1);
    chk("t2_nolimit_cnt", cycle_cnt_o, 32'd10001);

    // 3: window violations, boundaries and first capture
    pulse_start();
    chk("t3_cleared_cnt", cycle_cnt_o, 32'd0);
    write2(2'b11, 2'b11, 32'h001F_FFFC, 32'h0024_0004);
    chk("t3_viol_cnt", viol_cnt_o, 16'd2);
    chk("t3_viol_valid", viol_valid_o, 1'b1);
    chk("t3_viol_port", viol_port_o, 1'b0);
    chk("t3_viol_addr", viol_addr_o, 32'h0024_0004);
    write2(2'b11, 2'b11, 32'h0024_0000, 32'h0020_0000);
    chk("t3_bounds", viol_cnt_o, 16'd2);
    write2(2'b11, 2'b00, 32'h0000_0000, 32'h0100_0000);
    chk("t3_no_we", viol_cnt_o, 16'd2);
    write2(2'b10, 2'b10, 32'h0030_0000, 32'h0000_0000);
    chk("t3_cnt3", viol_cnt_o, 16'd3);
    chk("t3_keep_port", viol_port_o, 1'b0);
    chk("t3_keep_addr", viol_addr_o, 32'h0024_0004);
    chk("t3_still_run", status_o, 3'd1);

    // 4: exit reporting and event priority
    pulse_start();
    chk("t4_viol_clr", viol_cnt_o, 16'd0);
    chk("t4_valid_clr", viol_valid_o, 1'b0);
    exit_valid_i = 1'b1; exit_value_i = 32'd0;
    tick(1);
    exit_valid_i = 1'b0;
    chk("t4_exit_ok", status_o, 3'd4);
    chk("t4_exit_ok_done", done_o, 1'b1);
    pulse_start();
    exit_valid_i = 1'b1; exit_value_i = 32'd7; tests_passed_i = 1'b1;
    tick(1);
    exit_valid_i = 1'b0; tests_passed_i = 1'b0;
    chk("t4_pass_prio", status_o, 3'd2);
    chk("t4_pass_exitval", exit_value_o, 32'd0);
    pulse_start();
    tests_failed_i = 1'b1; tests_passed_i = 1'b1;
    tick(1);
    tests_failed_i = 1'b0; tests_passed_i = 1'b0;
    chk("t4_fail_prio", status_o, 3'd3);
    pulse_start();
    exit_valid_i = 1'b1; exit_value_i = 32'd7;
    tick(1);
    exit_valid_i = 1'b0; exit_value_i = 32'd0;
    chk("t4_exit_err", status_o, 3'd5);
    chk("t4_exit_val", exit_value_o, 32'd7);
    write2(2'b01, 2'b01, 32'h0, 32'h0000_0010);
    chk("t4_term_frozen", viol_cnt_o, 16'd0);
    chk("t4_term_valid", viol_valid_o, 1'b0);
    pulse_start();
    chk("t4_exit_clr", exit_value_o, 32'd0);

    // 5: fatal violation at RUN cycle 5
    pulse_start();
    tick(5);
    write2(2'b01, 2'b01, 32'h0, 32'h0000_0100);
    chk("t5_fatal_fail", f_status_o, 3'd3);
    chk("t5_fatal_cnt", f_cycle_cnt_o, 32'd5);
    chk("t5_fatal_viol", f_viol_cnt_o, 16'd1);
    chk("t5_fatal_addr", f_viol_addr_o, 32'h0000_0100);
    chk("t5_nonfatal_run", status_o, 3'd1);
    pulse_start();
    chk("t5_restart", f_status_o, 3'd1);
    chk("t5_restart_viol", f_viol_cnt_o, 16'd0);
    chk("t5_restart_valid", f_viol_valid_o, 1'b0);
    chk("t5_restart_cnt", f_cycle_cnt_o, 32'd0);

    // 6: asynchronous reset mid-run
    write2(2'b11, 2'b11, 32'h0000_0000, 32'h0030_0000);
    write2(2'b10, 2'b10, 32'h0040_0000, 32'h0);
    chk("t6_three", viol_cnt_o, 16'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_status", status_o, 3'd0);
    chk("t6_done", done_o, 1'b0);
    chk("t6_cycle", cycle_cnt_o, 32'd0);
    chk("t6_viol_cnt", viol_cnt_o, 16'd0);
    chk("t6_viol_valid", viol_valid_o, 1'b0);
    chk("t6_viol_addr", viol_addr_o, 32'd0);
    chk("t6_exit", exit_value_o, 32'd0);
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    tests_passed_i = 1'b1;
    write2(2'b01, 2'b01, 32'h0, 32'h0000_0004);
    tests_passed_i = 1'b0;
    chk("t6_idle_ignore", status_o, 3'd0);
    chk("t6_idle_viol", viol_cnt_o, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
